// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Output mode encodings, the default reset divisor and the channel-index width helper.
package clkdiv_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_TICK   = 1'b1;

    // 1 Hz square wave from a 50 MHz board clock.
    localparam int unsigned DIV_RST_DEFAULT = 25000000;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: programmable terminal count, square or pulse output, tick strobe.
// A write reloads the divisor/mode and restarts the phase; clr restarts the phase only.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RST_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    input  logic             en,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic             mode_reg, mode_next;
    logic             out_reg, out_next;
    logic             tick_reg, tick_next;
    logic [CNT_W-1:0] last_cnt;
    logic             at_term;

    // A divisor of 0 behaves as 1, so the terminal count is then 0 as well.
    assign last_cnt = (div_reg == '0) ? '0 : (div_reg - ONE);
    assign at_term  = (cnt_reg == last_cnt);

    always_comb begin
        cnt_next  = cnt_reg;
        div_next  = div_reg;
        mode_next = mode_reg;
        out_next  = out_reg;
        tick_next = 1'b0;
        if (wr || clr) begin
            if (wr) begin
                div_next  = wr_div;
                mode_next = wr_mode;
            end
            cnt_next = '0;
            out_next = 1'b0;
        end else if (en) begin
            if (at_term) begin
                cnt_next  = '0;
                tick_next = 1'b1;
                out_next  = (mode_reg == MODE_TICK) ? 1'b1 : ~out_reg;
            end else begin
                cnt_next = cnt_reg + ONE;
                out_next = (mode_reg == MODE_TICK) ? 1'b0 : out_reg;
            end
        end else if (mode_reg == MODE_TICK) begin
            out_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            div_reg  <= DIV_RST;
            mode_reg <= MODE_SQUARE;
            out_reg  <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            div_reg  <= div_next;
            mode_reg <= mode_next;
            out_reg  <= out_next;
            tick_reg <= tick_next;
        end
    end

    assign clk_out = out_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel runtime-programmable clock-enable generator.
// Decodes the config port into per-channel write strobes and replicates clkdiv_chan.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int          N_CH    = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DIV_RST = DIV_RST_DEFAULT,
    parameter int          CH_W    = ch_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic [N_CH-1:0]  en,
    input  logic             sync_clr,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] wr_vec;

    // Indices at or above N_CH match no channel, so such writes fall away.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign wr_vec[gi] = cfg_we && (int'(cfg_ch) == gi);

            clkdiv_chan #(
                .CNT_W   (CNT_W),
                .DIV_RST (CNT_W'(DIV_RST))
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .clr     (sync_clr),
                .wr      (wr_vec[gi]),
                .wr_div  (cfg_div),
                .wr_mode (cfg_mode),
                .en      (en[gi]),
                .clk_out (clk_out[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// Randomized self-checking bench for clkdiv_multi against an edge-count reference model.
// The model tracks enabled edges since the last clear and derives outputs arithmetically.
module tb_clkdiv_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int CH_W  = 3;
    localparam int DRST  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_mode = 1'b0;
    logic [N_CH-1:0]  en = '0;
    logic             sync_clr = 1'b0;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model state
    int n_m   [N_CH];
    int div_m [N_CH];
    bit mode_m[N_CH];
    bit tk_m  [N_CH];

    clkdiv_multi #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DIV_RST (DRST),
        .CH_W    (CH_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .en       (en),
        .sync_clr (sync_clr),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    function automatic int deff(input int i);
        return (div_m[i] == 0) ? 1 : div_m[i];
    endfunction

    function automatic logic [N_CH-1:0] exp_out();
        logic [N_CH-1:0] r;
        for (int i = 0; i < N_CH; i++)
            r[i] = mode_m[i] ? tk_m[i] : (((n_m[i] / deff(i)) % 2) == 1);
        return r;
    endfunction

    function automatic logic [N_CH-1:0] exp_tick();
        logic [N_CH-1:0] r;
        for (int i = 0; i < N_CH; i++) r[i] = tk_m[i];
        return r;
    endfunction

    task automatic model_edge();
        bit cleared[N_CH];
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                n_m[i] = 0; div_m[i] = DRST; mode_m[i] = 1'b0; tk_m[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) cleared[i] = sync_clr;
            if (cfg_we && int'(cfg_ch) < N_CH) begin
                div_m[cfg_ch]   = int'(cfg_div);
                mode_m[cfg_ch]  = cfg_mode;
                cleared[cfg_ch] = 1'b1;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (cleared[i]) begin
                    n_m[i] = 0; tk_m[i] = 1'b0;
                end else if (en[i]) begin
                    n_m[i] = n_m[i] + 1;
                    tk_m[i] = ((n_m[i] % deff(i)) == 0);
                end else begin
                    tk_m[i] = 1'b0;
                end
            end
        end
    endtask

    // Advance one clock; inputs are sampled at the edge, outputs settle by +1.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '0;
        step(); step();
        total++;
        if (clk_out !== 4'h0 || tick !== 4'h0)
            $display("FAIL reset_state cyc=%0d clk_out=%h tick=%h want 0/0", cyc, clk_out, tick);
        else passed++;
        rst = 1'b0; en = 4'hF;
        for (int c = 1; c <= 12; c++) begin
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick())
                $display("FAIL reset_release cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
            if (c == 5 || c == 10) begin
                total++;
                if (clk_out !== ((c == 5) ? 4'hF : 4'h0) || tick !== 4'hF)
                    $display("FAIL reset_edge%0d clk_out=%h tick=%h want %h/F",
                             c, clk_out, tick, (c == 5) ? 4'hF : 4'h0);
                else passed++;
            end
        end
    endtask

    task automatic test_write_ch2();
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd3; cfg_mode = 1'b1;
        step();
        cfg_we = 1'b0;
        total++;
        if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0)
            $display("FAIL write_clear cyc=%0d clk_out2=%b tick2=%b want 0/0", cyc, clk_out[2], tick[2]);
        else passed++;
        for (int c = 1; c <= 12; c++) begin
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick())
                $display("FAIL write_ch2 cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
            total++;
            if (clk_out[2] !== ((c % 3) == 0))
                $display("FAIL write_pulse cyc=%0d clk_out2=%b want %b", cyc, clk_out[2], (c % 3) == 0);
            else passed++;
        end
    endtask

    task automatic test_div_edge();
        for (int k = 0; k < 3; k++) begin
            cfg_we = 1'b1; cfg_ch = 3'd1; cfg_mode = (k == 2);
            cfg_div = (k == 1) ? 8'd1 : 8'd0;
            step();
            cfg_we = 1'b0;
            for (int c = 1; c <= 6; c++) begin
                step();
                total++;
                if (clk_out !== exp_out() || tick !== exp_tick())
                    $display("FAIL div_edge%0d cyc=%0d clk_out=%h want %h tick=%h want %h",
                             k, cyc, clk_out, exp_out(), tick, exp_tick());
                else passed++;
                total++;
                if (clk_out[1] !== ((k == 2) ? 1'b1 : c[0]))
                    $display("FAIL div_edge_ch1_%0d cyc=%0d clk_out1=%b want %b",
                             k, cyc, clk_out[1], (k == 2) ? 1'b1 : c[0]);
                else passed++;
            end
        end
    endtask

    task automatic test_en_gate();
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd5; cfg_mode = 1'b0; en = 4'hF;
        step();
        cfg_we = 1'b0;
        step(); step();
        en[0] = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick() || tick[0] !== 1'b0)
                $display("FAIL en_gate cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
        end
        en[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++;
            if (tick[0] !== (c == 3) || clk_out[0] !== (c == 3))
                $display("FAIL en_resume cyc=%0d tick0=%b clk_out0=%b want %b/%b",
                         cyc, tick[0], clk_out[0], c == 3, c == 3);
            else passed++;
        end
    endtask

    task automatic test_sync_and_write();
        repeat (3) step();
        sync_clr = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd4; cfg_mode = 1'b0; en = 4'hF;
        step();
        sync_clr = 1'b0; cfg_we = 1'b0;
        total++;
        if (clk_out !== 4'h0 || tick !== 4'h0)
            $display("FAIL sync_clear cyc=%0d clk_out=%h tick=%h want 0/0", cyc, clk_out, tick);
        else passed++;
        for (int c = 1; c <= 20; c++) begin
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick() || clk_out[3] !== (((c / 4) % 2) == 1))
                $display("FAIL sync_run cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
        end
    endtask

    task automatic test_bad_ch();
        cfg_we = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd1; cfg_mode = 1'b1;
        step();
        cfg_we = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick())
                $display("FAIL bad_ch cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
        end
    endtask

    task automatic test_big_div();
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd255; cfg_mode = 1'b1; en = 4'hF;
        step();
        cfg_we = 1'b0;
        for (int c = 1; c <= 260; c++) begin
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick() || tick[0] !== (c == 255))
                $display("FAIL big_div cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 7));
            cfg_div  = CNT_W'($urandom_range(0, 7));
            cfg_mode = $urandom_range(0, 1) == 1;
            sync_clr = ($urandom_range(0, 19) == 0);
            en       = N_CH'($urandom_range(0, 15)) | N_CH'($urandom_range(0, 15));
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick())
                $display("FAIL random cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
        end
        cfg_we = 1'b0; sync_clr = 1'b0; en = 4'hF;
    endtask

    task automatic test_reset_mid();
        repeat (2) step();
        rst = 1'b1;
        step();
        total++;
        if (clk_out !== 4'h0 || tick !== 4'h0)
            $display("FAIL reset_mid cyc=%0d clk_out=%h tick=%h want 0/0", cyc, clk_out, tick);
        else passed++;
        rst = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step();
            total++;
            if (clk_out !== exp_out() || tick !== exp_tick() || clk_out !== ((((c / 5) % 2) == 1) ? 4'hF : 4'h0))
                $display("FAIL reset_mid_run cyc=%0d clk_out=%h want %h tick=%h want %h",
                         cyc, clk_out, exp_out(), tick, exp_tick());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write_ch2();
        test_div_edge();
        test_en_gate();
        test_sync_and_write();
        test_bad_ch();
        test_big_div();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Multi-channel, runtime-programmable clock divider and tick generator for the elevator controller. It produces up to N_CH independent slow enables and square waves from the single board clock: door timer, floor-travel timer, display blink, and so on. Each channel has its own divisor and its own output mode, both set through a simple write port. A global synchronous clear realigns all channels in phase. Outputs are registered and intended as clock enables, not as clocks for other logic.

## Interface
- N_CH, 4: number of independent channels (1..16)
- CNT_W, 32: counter and divisor width
- DIV_RST, 25000000: divisor loaded into every channel at reset (1 Hz square wave at 50 MHz)
- CH_W, $clog2(N_CH) (min 1): width of channel index (derived)

- clk  in  1  single system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  CH_W  channel addressed by cfg_we
- cfg_div  in  CNT_W  terminal count D (half-period in square mode, period in tick mode)
- cfg_mode  in  1  0 = square (toggle at terminal), 1 = pulse (one-cycle high at terminal)
- en  in  N_CH  per-channel count enable
- sync_clr  in  1  restart all channels: counters and outputs to 0, config kept
- clk_out  out  N_CH  per-channel divided output, according to mode
- tick  out  N_CH  per-channel one-cycle pulse at every terminal count, in either mode

## Operation
- Per channel: registers cnt[CNT_W], div[CNT_W], mode, out, tick.
- Reset values: cnt=0, div=DIV_RST, mode=0, clk_out=0, tick=0 for all channels.
- Effective divisor: Deff = (div==0) ? 1 : div.
- When en[i]=1 and cnt==Deff-1:
  - cnt<=0 and tick<=1.
  - Mode 0: out<=~out.
  - Mode 1: out<=1.
- When en[i]=1 and cnt!=Deff-1:
  - cnt<=cnt+1 and tick<=0.
  - Mode 0: out holds.
  - Mode 1: out<=0.
- When en[i]=0:
  - cnt and the mode-0 out hold.
  - tick<=0.
  - Mode-1 out<=0.
- Config write (cfg_we=1, cfg_ch<N_CH):
  - The addressed channel latches div<=cfg_div and mode<=cfg_mode.
  - It also clears cnt, out and tick, giving a clean restart with the new divisor.
  - Other channels are unaffected.
- cfg_ch>=N_CH: the write is ignored entirely.
- sync_clr=1: every channel's cnt, out and tick are cleared; div and mode are unchanged.
- Priority is rst > (cfg_we, sync_clr) > counting. If cfg_we and sync_clr occur in the same cycle, the config is latched and all channels are cleared.
- Counter wrap: cnt never exceeds Deff-1, so no overflow is possible. div=2^CNT_W-1 is legal.

## Timing
- Latency: after a clear (reset, write or sync_clr) with en held high, the first terminal occurs on the D-th enabled edge. clk_out and tick change on that same edge, visible in the following cycle.
- Mode 0 period is 2·Deff enabled cycles at 50% duty; Deff=1 gives clk/2.
- Mode 1 and tick period is Deff enabled cycles with a 1-cycle high; Deff=1 gives a constant 1 while enabled.
- A config write takes effect on the next edge. The first terminal with the new divisor occurs D enabled edges after the write edge.
- Gating en low mid-count freezes the phase. On re-enable, counting resumes from the held cnt with no extra cycle.
- Reset asserted mid-count returns all outputs to 0 on the same edge.

## Structure
- Package clkdiv_pkg holds:
  - MODE_SQUARE=1'b0 and MODE_TICK=1'b1;
  - the default DIV_RST value;
  - a helper for CH_W.
- Sub-module clkdiv_chan implements one channel: cnt/div/mode registers, terminal compare, out/tick logic. Its ports are clk, rst, clr, wr, wr_div, wr_mode, en, clk_out and tick.
- clkdiv_multi decodes cfg_ch into per-channel wr strobes and instantiates N_CH copies of clkdiv_chan in a generate loop.

## Test plan
- Reset release with N_CH=4, DIV_RST=5, en=4'hF: every clk_out rises after edge 5, falls after edge 10; each tick is high exactly one cycle every 5 cycles.
- Write ch2 with div=3, mode=1 at cycle 20: ch2 clk_out=0 next cycle, then a 1-cycle pulse every 3 cycles starting 3 edges after the write; ch0, ch1 and ch3 waveforms are undisturbed.
- div=0 and div=1 on ch1, mode 0: clk_out toggles every cycle for both. Mode 1: clk_out is held at 1 while en=1.
- Drop en[0] for 7 cycles when cnt=2 (D=5): clk_out[0] holds and tick[0]=0; after re-enable, the terminal occurs 3 enabled edges later.
- Assert sync_clr and cfg_we (ch3, div=4) together mid-run: all cnt/out clear; ch3 then toggles every 4 cycles; ch0 to ch2 keep div=5, and all channels are phase-aligned.
- Write with cfg_ch=5 when N_CH=4: no channel changes. Assert rst mid-count: all outputs are 0 on the next cycle and div returns to DIV_RST.
